// File: rtl/shift_sequencer.sv
// Sequencer for an external shift register that shifts every cycle unless loaded:
// IDLE -> LOAD -> SHIFT (len bits) -> DONE. Define SHIFT_SEQUENCER_ROTATE_EN for the rotate option.
module shift_sequencer #(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [W-1:0]  tx_data,
  input  logic          dir,
  input  logic [CW-1:0] len,
  input  logic          stall,
  input  logic          abort,
  input  logic          rx_in,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic          rot,
`endif
  output logic          serial_out,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  rx_data,
  output logic          sr_load,
  output logic          sr_dir,
  output logic          sr_serial_in,
  output logic [W-1:0]  sr_load_value,
  input  logic [W-1:0]  sr_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_norm_s;
  logic          accept_s;
  logic          shift_en_s;
  logic          last_shift_s;
  logic          serial_bit_s;
  logic          rot_sel_s;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic rot_q, rot_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_q <= 1'b0;
    end else begin
      rot_q <= rot_d;
    end
  end

  always_comb begin
    if (accept_s) begin
      rot_d = rot;
    end else begin
      rot_d = rot_q;
    end
  end

  assign rot_sel_s = rot_q;
`else
  assign rot_sel_s = 1'b0;
`endif

  // A zero or oversized length means a full-width transfer.
  assign len_norm_s   = ((len == {CW{1'b0}}) || (len > CW'(W))) ? CW'(W) : len;
  assign accept_s     = (state_q == ST_IDLE) && start_valid;
  assign shift_en_s   = (state_q == ST_SHIFT) && !abort && !stall;
  assign last_shift_s = shift_en_s && (cnt_q == CW'(1));
  assign serial_bit_s = dir_q ? sr_q[0] : sr_q[W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= {W{1'b0}};
      dir_q   <= 1'b0;
      len_q   <= {CW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_shift_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d = tx_data;
          dir_d  = dir;
          len_d  = len_norm_s;
        end else begin
          data_d = data_q;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = len_q;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          cnt_d = {CW{1'b0}};
        end else if (shift_en_s) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: cnt_d = {CW{1'b0}};
      default: cnt_d = {CW{1'b0}};
    endcase
  end

  // Any cycle that is not a real shift reloads the register with its own value.
  always_comb begin
    start_ready   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    rx_data       = {W{1'b0}};
    serial_out    = 1'b0;
    sr_load       = 1'b1;
    sr_load_value = sr_q;
    sr_dir        = 1'b0;
    sr_serial_in  = 1'b0;
    case (state_q)
      ST_IDLE: start_ready = 1'b1;
      ST_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          sr_load_value = sr_q;
        end else begin
          sr_load_value = data_q;
        end
      end
      ST_SHIFT: begin
        busy       = 1'b1;
        serial_out = serial_bit_s;
        if (shift_en_s) begin
          sr_load      = 1'b0;
          sr_dir       = dir_q;
          sr_serial_in = rot_sel_s ? serial_bit_s : rx_in;
        end else begin
          sr_load_value = sr_q;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        rx_data = sr_q;
      end
      default: start_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external register and predicts every output
// from transfer-level arithmetic; directed vectors pin latency and result words.
module tb_shift_sequencer;
  localparam int W  = 16;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_valid = 1'b0;
  logic          dir = 1'b0;
  logic          stall = 1'b0;
  logic          abort = 1'b0;
  logic          rx_in = 1'b0;
  logic          rot_r = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic [CW-1:0] len = '0;
  logic          start_ready, serial_out, busy, done, sr_load, sr_dir, sr_serial_in;
  logic [W-1:0]  rx_data, sr_load_value;
  logic [W-1:0]  sr_q_r = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // transfer-level model
  bit           m_load = 0, m_shift = 0, m_done = 0;
  bit           m_dir = 0, m_r = 0, m_rot = 0;
  int           m_shifts = 0, m_n = 0;
  logic [W-1:0] m_tx = '0, m_hold = '0;
  int           acc_cyc = 0, done_cyc = 0, done_count = 0;
  logic [W-1:0] last_rx = '0, ser_word = '0;

  shift_sequencer #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .tx_data(tx_data), .dir(dir), .len(len),
    .stall(stall), .abort(abort), .rx_in(rx_in),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .rot(rot_r),
`endif
    .serial_out(serial_out), .busy(busy), .done(done), .rx_data(rx_data),
    .sr_load(sr_load), .sr_dir(sr_dir), .sr_serial_in(sr_serial_in),
    .sr_load_value(sr_load_value), .sr_q(sr_q_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // the controlled register: loads, or shifts left (dir 0) / right (dir 1)
  always @(posedge clk) begin
    if (sr_load) sr_q_r <= sr_load_value;
    else if (!sr_dir) sr_q_r <= {sr_q_r[W-2:0], sr_serial_in};
    else sr_q_r <= {sr_serial_in, sr_q_r[W-1:1]};
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // register contents after k shifts of tx, by plain arithmetic
  function automatic logic [W-1:0] shifted(logic [W-1:0] tx, bit d, bit r, bit ro, int k);
    longint unsigned v, mask, res;
    v = 64'(tx);
    mask = (64'd1 << W) - 64'd1;
    if (k == 0) return tx;
    if (ro) res = d ? ((v >> k) | (v << (W - k))) : ((v << k) | (v >> (W - k)));
    else if (d) res = (v >> k) | (r ? (mask ^ (mask >> k)) : 64'd0);
    else res = (v << k) | (r ? ((64'd1 << k) - 64'd1) : 64'd0);
    return W'(res & mask);
  endfunction

  function automatic logic out_bit(int k);
    return m_dir ? m_tx[k] : m_tx[W-1-k];
  endfunction

  // compare every cycle, then advance the model across the coming edge
  always @(negedge clk) begin : mon
    logic [W-1:0] exp_q;
    logic shifting;
    if (reset) begin
      if (m_shift) m_hold = shifted(m_tx, m_dir, m_r, m_rot, m_shifts);
      m_load = 0; m_shift = 0; m_done = 0;
    end
    if (m_shift) exp_q = shifted(m_tx, m_dir, m_r, m_rot, m_shifts);
    else if (m_done) exp_q = shifted(m_tx, m_dir, m_r, m_rot, m_n);
    else exp_q = m_hold;
    shifting = m_shift && !abort && !stall;

    chkw("sr_q", sr_q_r, exp_q);
    chk1("busy", busy, m_load || m_shift);
    chk1("done", done, m_done);
    chkw("rx_data", rx_data, m_done ? exp_q : '0);
    if (!reset) chk1("start_ready", start_ready, !(m_load || m_shift || m_done));
    chk1("serial_out", serial_out, m_shift ? out_bit(m_shifts) : 1'b0);
    chk1("sr_load", sr_load, !shifting);
    if (shifting) begin
      chk1("sr_dir", sr_dir, m_dir);
      chk1("sr_serial_in", sr_serial_in, m_rot ? out_bit(m_shifts) : rx_in);
      ser_word = {ser_word[W-2:0], serial_out};
    end else if (m_load && !abort) begin
      chkw("sr_load_value_load", sr_load_value, m_tx);
    end else begin
      chkw("sr_load_value_hold", sr_load_value, sr_q_r);
    end
    if (done) begin
      done_count++;
      last_rx = rx_data;
      done_cyc = cyc;
    end

    if (!reset) begin
      if (m_done) begin
        m_hold = exp_q; m_done = 0;
      end else if (m_load) begin
        m_load = 0;
        if (!abort) begin m_shift = 1; m_shifts = 0; end
      end else if (m_shift) begin
        if (abort) begin
          m_hold = exp_q; m_shift = 0;
        end else if (!stall) begin
          m_shifts++;
          if (m_shifts == m_n) begin m_shift = 0; m_done = 1; end
        end
      end else if (start_valid) begin
        m_load = 1;
        m_tx = tx_data; m_dir = dir; m_r = rx_in;
        m_n = (int'(len) == 0 || int'(len) > W) ? W : int'(len);
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        m_rot = rot_r;
`else
        m_rot = 1'b0;
`endif
        acc_cyc = cyc;
        ser_word = '0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] t, input logic d, input logic [CW-1:0] l,
                       input logic r, input logic ro);
    tx_data = t; dir = d; len = l; rx_in = r; rot_r = ro; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0;
    n0 = done_count;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_count != n0) break;
    end
    chki({name, "_done_seen"}, done_count - n0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_sr_load", sr_load, 1'b1);
    chkw("rst_rx_data", rx_data, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk1("rst_start_ready", start_ready, 1'b1);
    @(posedge clk); #1;

    issue(16'hA5C3, 1'b0, 5'd16, 1'b0, 1'b0);
    wait_done("t1", 40);
    chki("t1_latency", done_cyc - acc_cyc, 18);
    chkw("t1_rx", last_rx, 16'h0000);
    chkw("t1_serial_seq", ser_word, 16'hA5C3);

    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;

    issue(16'h3C96, 1'b0, 5'd8, 1'b0, 1'b0);
    wait_done("t3a", 30);
    chki("t3a_latency", done_cyc - acc_cyc, 10);
    chkw("t3a_rx", last_rx, 16'h9600);

    issue(16'h3C96, 1'b0, 5'd8, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done("t3b", 30);
    chki("t3b_latency", done_cyc - acc_cyc, 13);
    chkw("t3b_rx", last_rx, 16'h9600);

    issue(16'hA5C3, 1'b0, 5'd16, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    #3 chk1("t4_busy_after_abort", busy, 1'b0);
    n0 = done_count;
    repeat (20) @(posedge clk);
    #1;
    chki("t4_no_done", done_count - n0, 0);
    chkw("t4_frozen", sr_q_r, 16'hB860);

    issue(16'h00F0, 1'b1, 5'd4, 1'b1, 1'b0);
    wait_done("t2", 20);
    chki("t2_latency", done_cyc - acc_cyc, 6);
    chkw("t2_rx", last_rx, 16'hF00F);

    issue(16'h1234, 1'b1, 5'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 start_valid = 1'b1; tx_data = 16'hFFFF;
    #1 chk1("t5_ready_in_shift", start_ready, 1'b0);
    repeat (5) @(posedge clk);
    #1 start_valid = 1'b0;
    wait_done("t5", 40);
    chki("t5_latency", done_cyc - acc_cyc, 18);
    chkw("t5_serial_seq", ser_word, 16'h2C48);
    chkw("t5_rx", last_rx, 16'h0000);

    issue(16'hFFFF, 1'b0, 5'd31, 1'b0, 1'b0);
    wait_done("t6", 40);
    chki("t6_latency", done_cyc - acc_cyc, 18);
    chkw("t6_rx", last_rx, 16'h0000);

    issue(16'h00F0, 1'b1, 5'd8, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n0 = done_count;
    repeat (15) @(posedge clk);
    #1;
    chki("t7_no_done", done_count - n0, 0);
    chk1("t7_busy", busy, 1'b0);
    chk1("t7_ready", start_ready, 1'b1);
    chkw("t7_held", sr_q_r, 16'h001E);

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    issue(16'h8001, 1'b0, 5'd4, 1'b0, 1'b1);
    wait_done("t8", 20);
    chkw("t8_rot_rx", last_rx, 16'h0018);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter W, 16, data width of the controlled shift register (W >= 2).
REQ-002 The block SHALL have parameter CW, $clog2(W)+1, width of the length field and bit counter.
REQ-003 The block SHALL have port clk input 1, clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port reset input 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start_valid input 1, a transfer request.
REQ-006 The block SHALL have port start_ready output 1, asserted when a request is accepted this cycle.
REQ-007 The block SHALL have port tx_data input W, the word to load into the register.
REQ-008 The block SHALL have port dir input 1, shift direction: 0 left, 1 right.
REQ-009 The block SHALL have port len input CW, the number of bits to shift (1..W; 0 is treated as W; values >W are clamped to W).
REQ-010 The block SHALL have port stall input 1, which freezes shifting while high.
REQ-011 The block SHALL have port abort input 1, which cancels the current transfer.
REQ-012 The block SHALL have port rx_in input 1, the serial data fed into the register.
REQ-013 The block SHALL have port serial_out output 1, the bit currently leaving the register.
REQ-014 The block SHALL have port busy output 1, high in the LOAD and SHIFT states.
REQ-015 The block SHALL have port done output 1, a one-cycle completion pulse.
REQ-016 The block SHALL have port rx_data output W, the register contents, valid while done is high.
REQ-017 The block SHALL have port sr_load output 1, driving the register's load_condition.
REQ-018 The block SHALL have port sr_dir output 1, driving the register's shift_condition.
REQ-019 The block SHALL have port sr_serial_in output 1, driving the register's serial_in.
REQ-020 The block SHALL have port sr_load_value output W, driving the register's load_value.
REQ-021 The block SHALL have port sr_q input W, the register's register_out.

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-023 Because the register shifts every cycle unless loading, every non-shifting cycle SHALL drive sr_load=1 with sr_load_value=sr_q (hold).
REQ-024 In IDLE, start_ready SHALL be 1; on start_valid&&start_ready the block SHALL capture tx_data, dir and the normalised len, then go to LOAD.
REQ-025 In LOAD, sr_load SHALL be 1 and sr_load_value SHALL be the captured tx_data; the counter SHALL be set to len; the next state SHALL be SHIFT.
REQ-026 In SHIFT with stall=0, the block SHALL drive sr_load=0, sr_dir=captured dir and sr_serial_in=rx_in, and SHALL decrement the counter.
REQ-027 In SHIFT with stall=1, the block SHALL drive sr_load=1 with sr_load_value=sr_q, and the counter SHALL hold.
REQ-028 When a non-stalled shift occurs with the counter at 1, the next state SHALL be DONE.
REQ-029 In DONE, done SHALL be 1 for exactly one cycle, rx_data SHALL equal sr_q, the register SHALL be held, and the next state SHALL be IDLE.
REQ-030 serial_out SHALL be sr_q[W-1] for left shifts and sr_q[0] for right shifts; it SHALL be 0 outside SHIFT.
REQ-031 With no stall, latency SHALL be: accept at edge E0, load at E1, the len-th shift at E(1+len), and done high during the cycle following E(1+len).
REQ-032 start_valid outside IDLE SHALL be ignored (start_ready=0), with no queuing.
REQ-033 abort in LOAD or SHIFT SHALL return the FSM to IDLE at the next edge, without a done pulse and with the register held; abort SHALL have priority over stall and completion.
REQ-034 abort in IDLE or DONE SHALL have no effect.
REQ-035 rx_data SHALL be 0 whenever done=0.

Reset
REQ-036 reset SHALL asynchronously force the IDLE state, counter=0 and captured fields=0.
REQ-037 During and after reset, the outputs SHALL be busy=0, done=0, serial_out=0, rx_data=0, sr_load=1, sr_load_value=sr_q and start_ready=1 once reset is deasserted.
REQ-038 Reset mid-transfer SHALL discard the transfer, and no done pulse SHALL follow it.

Configuration
REQ-039 The feature SHALL be controlled by the macro SHIFT_SEQUENCER_ROTATE_EN.
REQ-040 With SHIFT_SEQUENCER_ROTATE_EN defined, the block SHALL add an input port rot (1 bit) captured at accept; when the captured rot=1, sr_serial_in SHALL equal serial_out (rotation) instead of rx_in.
REQ-041 Without SHIFT_SEQUENCER_ROTATE_EN, the rot port SHALL be absent and sr_serial_in SHALL always equal rx_in during SHIFT.

Verification
REQ-042 The bench SHALL cover: W=16, tx_data=16'hA5C3, dir=0, len=16, rx_in=0 -> serial_out MSB-first sequence 1010010111000011, done in cycle 18 after accept, rx_data=16'h0000.
REQ-043 The bench SHALL cover: tx_data=16'h00F0, dir=1, len=4, rx_in=1 -> rx_data=16'hF00F, done in cycle 6 after accept.
REQ-044 The bench SHALL cover: len=8 with stall high for 3 cycles mid-SHIFT -> done delayed by exactly 3 cycles, rx_data identical to the unstalled run.
REQ-045 The bench SHALL cover: abort after 5 shifts -> busy=0 next cycle, no done, sr_q frozen; a new start_valid is then accepted.
REQ-046 The bench SHALL cover: start_valid held during SHIFT -> start_ready=0, ignored; len=0 -> 16 shifts performed.
REQ-047 The bench SHALL cover: with ROTATE_EN, tx_data=16'h8001, dir=0, len=4, rot=1 -> rx_data=16'h0018.
